// File: rtl/uart_pkg.sv
// Shared UART types: TX scheduler state encoding, default byte width, source indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Source indices as seen on empty/r_req bit positions and grant_id.
    localparam logic SRC_ECHO = 1'b0;
    localparam logic SRC_HOST = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_DATA,
        WAIT_START,
        WAIT_DONE
    } uart_tx_sched_state_t;

    // One-hot read request for a source index.
    function automatic logic [1:0] src_onehot(input logic src);
        return (src == SRC_HOST) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bundle between the TX scheduler, the two source FIFOs and the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: FIFO side by empty flags, transmitter side by tx_busy.
// Ports: empty/r_req/r_data0/r_data1 face the FIFOs; tx_busy/tx_start/tx_data face the
// transmitter; grant_id and timeout_err are status. master = scheduler, slave = environment.
interface uart_tx_sched_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        empty;
    logic [1:0]        r_req;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              grant_id;
    logic              timeout_err;

    modport master (
        input  empty, r_data0, r_data1, tx_busy,
        output r_req, tx_start, tx_data, grant_id, timeout_err
    );

    modport slave (
        output empty, r_data0, r_data1, tx_busy,
        input  r_req, tx_start, tx_data, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_rr_arb2.sv
// Two-requester round-robin pick: one-hot grant from request bits and preference pointer.
// Latency: combinational.
// Backpressure: none; grant is zero when nothing requests.
// Ports: req[n] = source n has data; ptr = preferred source on contention; gnt = one-hot grant.
module uart_rr_arb2
    import uart_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = src_onehot(ptr);
        end else begin
            // Zero or one requester: the request itself is already one-hot (or empty).
            gnt = req;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between echo (src 0) and host (src 1) FIFOs.
// Latency: tx_start two cycles after the IDLE edge that issues r_req; next grant 1 cycle after tx_busy falls.
// Backpressure: never issues a read while tx_busy is high; one byte in flight at a time.
// Ports: SYS_CLK, RST_N (async, active-low); bus (master modport) carries FIFO and transmitter signals.
// Build option UART_TX_SCHED_TIMEOUT_EN: adds a TIMEOUT_CYC watchdog on tx_busy rising after tx_start.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int DATA_W      = UART_DATA_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic         SYS_CLK,
    input  logic         RST_N,
    uart_tx_sched_if.master bus
);

    uart_tx_sched_state_t state_q, state_d;

    logic              ptr_q, ptr_d;          // preferred source when both have data
    logic [1:0]        r_req_q, r_req_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              grant_q, grant_d;
    logic [1:0]        gnt;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
`endif

    uart_rr_arb2 u_arb (
        .req (~bus.empty),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        r_req_d    = 2'b00;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        cnt_d      = cnt_q;
        terr_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // empty is only looked at here; the arbiter already resolves contention.
                if (!bus.tx_busy && (gnt != 2'b00)) begin
                    r_req_d = gnt;
                    grant_d = gnt[1];
                    state_d = READ;
                end
            end
            READ: begin
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                // FIFO read data is valid the cycle after r_req.
                tx_data_d  = grant_q ? bus.r_data1 : bus.r_data0;
                tx_start_d = 1'b1;
                state_d    = WAIT_START;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            WAIT_START: begin
                // A tx_busy rise is checked first so it wins on the final counted cycle.
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Byte is dropped; pointer stays so the same source is preferred again.
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    ptr_d   = ~grant_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            ptr_q      <= SRC_ECHO;
            r_req_q    <= 2'b00;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            r_req_q    <= r_req_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.r_req    = r_req_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: FIFO and transmitter models plus a byte scoreboard.
// Latency: n/a.
// Backpressure: transmitter model holds tx_busy for FRAME cycles per tx_start.
module tb_uart_tx_sched;
    import uart_pkg::*;

    localparam int TO_CYC = 16;
    localparam int FRAME  = 6;

    logic SYS_CLK = 1'b0;
    logic RST_N   = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    uart_tx_sched_if #(.DATA_W(8)) bus ();

    uart_tx_sched #(
        .DATA_W      (8),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .SYS_CLK (SYS_CLK),
        .RST_N   (RST_N),
        .bus     (bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       gid;
    } exp_t;

    typedef struct {
        logic [1:0] load;   // bit n: push a byte into source n
        logic [7:0] d0;
        logic [7:0] d1;
        logic       first;  // source expected to be granted first
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    exp_t       sb[$];
    exp_t       mon_e;
    bit         manual = 1'b0;   // bench drives tx_busy directly
    bit         dead   = 1'b0;   // transmitter ignores tx_start
    int         busy_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void upd_empty();
        bus.empty = {q1.size() == 0, q0.size() == 0};
    endfunction

    function automatic bit idle_now();
        return (sb.size() == 0) && (q0.size() == 0) && (q1.size() == 0) &&
               (dut.state_q == IDLE) && !bus.tx_busy;
    endfunction

    task automatic wait_idle(input string nm);
        int n = 0;
        do begin
            @(negedge SYS_CLK);
            n++;
        end while (!idle_now() && n < 300);
        chk(nm, idle_now(), 1);
    endtask

    // FIFO + transmitter model, updated away from the DUT's active edge.
    always @(negedge SYS_CLK) begin
        if (!RST_N) begin
            busy_cnt = 0;
        end else begin
            if (bus.r_req != 2'b00) chk("rreq_onehot", $countones(bus.r_req), 1);
            if (bus.r_req[0]) begin
                chk("rreq0_nonempty", q0.size() > 0, 1);
                if (q0.size() > 0) bus.r_data0 = q0.pop_front();
            end
            if (bus.r_req[1]) begin
                chk("rreq1_nonempty", q1.size() > 0, 1);
                if (q1.size() > 0) bus.r_data1 = q1.pop_front();
            end
            upd_empty();
            if (bus.tx_start && !dead) busy_cnt = FRAME;
            else if (busy_cnt > 0)     busy_cnt--;
        end
        if (!manual) bus.tx_busy = (busy_cnt != 0);
    end

    // Scoreboard: every launched byte must match the next expected byte and source.
    always @(negedge SYS_CLK) begin
        if (RST_N && bus.tx_start) begin
            if (sb.size() == 0) begin
                chk("tx_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("tx_data", bus.tx_data, mon_e.data);
                chk("tx_grant_id", bus.grant_id, mon_e.gid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int   n;
        int   bad;

        tbl[0] = '{2'b10, 8'h00, 8'h3C, 1'b1};
        tbl[1] = '{2'b01, 8'h5A, 8'h00, 1'b0};
        tbl[2] = '{2'b11, 8'hC3, 8'h3C, 1'b1};
        tbl[3] = '{2'b10, 8'h00, 8'h81, 1'b1};
        tbl[4] = '{2'b11, 8'h00, 8'hFF, 1'b0};
        tbl[5] = '{2'b01, 8'h7E, 8'h00, 1'b0};
        tbl[6] = '{2'b10, 8'h00, 8'hE7, 1'b1};

        bus.empty   = 2'b11;
        bus.r_data0 = 8'h00;
        bus.r_data1 = 8'h00;
        bus.tx_busy = 1'b0;

        // Reset state
        #1;
        chk("rst_r_req", bus.r_req, 2'b00);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        chk("rst_state", dut.state_q == IDLE, 1);
        repeat (3) @(negedge SYS_CLK);
        RST_N = 1'b1;

        // Single byte with exact timing (pointer 0 -> 1 afterwards)
        @(negedge SYS_CLK);
        q0.push_back(8'hA5);
        sb.push_back('{data: 8'hA5, gid: 1'b0});
        upd_empty();
        @(negedge SYS_CLK);
        chk("single_r_req", bus.r_req, 2'b01);
        chk("single_no_start_yet", bus.tx_start, 0);
        @(negedge SYS_CLK);
        chk("single_r_req_cleared", bus.r_req, 2'b00);
        @(negedge SYS_CLK);
        chk("single_tx_start", bus.tx_start, 1);
        chk("single_tx_data", bus.tx_data, 8'hA5);
        @(negedge SYS_CLK);
        chk("single_tx_start_pulse", bus.tx_start, 0);
        wait_idle("single_done");

        // Table-driven grant order
        for (int i = 0; i < 7; i++) begin
            @(negedge SYS_CLK);
            if (tbl[i].load[0]) q0.push_back(tbl[i].d0);
            if (tbl[i].load[1]) q1.push_back(tbl[i].d1);
            if (tbl[i].first == 1'b0) begin
                if (tbl[i].load[0]) sb.push_back('{data: tbl[i].d0, gid: 1'b0});
                if (tbl[i].load[1]) sb.push_back('{data: tbl[i].d1, gid: 1'b1});
            end else begin
                if (tbl[i].load[1]) sb.push_back('{data: tbl[i].d1, gid: 1'b1});
                if (tbl[i].load[0]) sb.push_back('{data: tbl[i].d0, gid: 1'b0});
            end
            upd_empty();
            wait_idle($sformatf("vec%0d_done", i));
        end

        // Contention: alternating 11,21,12,22,13,23
        @(negedge SYS_CLK);
        for (int i = 0; i < 3; i++) begin
            q0.push_back(8'h11 + 8'(i));
            q1.push_back(8'h21 + 8'(i));
        end
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{data: 8'h11 + 8'(i), gid: 1'b0});
            sb.push_back('{data: 8'h21 + 8'(i), gid: 1'b1});
        end
        upd_empty();
        wait_idle("contention_done");

        // tx_busy held high in IDLE blocks the grant
        @(negedge SYS_CLK);
        manual      = 1'b1;
        bus.tx_busy = 1'b1;
        q1.push_back(8'hD2);
        sb.push_back('{data: 8'hD2, gid: 1'b1});
        upd_empty();
        bad = 0;
        repeat (6) begin
            @(negedge SYS_CLK);
            if (bus.r_req != 2'b00) bad++;
        end
        chk("busy_hold_no_r_req", bad, 0);
        bus.tx_busy = 1'b0;
        @(negedge SYS_CLK);
        chk("busy_release_r_req", bus.r_req, 2'b10);
        manual = 1'b0;
        wait_idle("busy_done");

        // Transmitter never starts
        @(negedge SYS_CLK);
        dead = 1'b1;
        q0.push_back(8'hC1);
        q0.push_back(8'hC2);
        q1.push_back(8'hD1);
        sb.push_back('{data: 8'hC1, gid: 1'b0});
`ifdef UART_TX_SCHED_TIMEOUT_EN
        sb.push_back('{data: 8'hC2, gid: 1'b0});
        sb.push_back('{data: 8'hD1, gid: 1'b1});
`else
        sb.push_back('{data: 8'hD1, gid: 1'b1});
        sb.push_back('{data: 8'hC2, gid: 1'b0});
`endif
        upd_empty();
        n = 0;
        while (!bus.tx_start && n < 20) begin
            @(negedge SYS_CLK);
            n++;
        end
        chk("to_start_seen", bus.tx_start, 1);
`ifdef UART_TX_SCHED_TIMEOUT_EN
        n = 0;
        bad = 0;
        while (n < 40 && bad == 0) begin
            @(negedge SYS_CLK);
            n++;
            if (bus.timeout_err) bad = 1;
        end
        chk("to_latency", n, TO_CYC);
        chk("to_state_idle", dut.state_q == IDLE, 1);
        dead = 1'b0;
        @(negedge SYS_CLK);
        chk("to_pulse_width", bus.timeout_err, 0);
`else
        bad = 0;
        repeat (40) begin
            @(negedge SYS_CLK);
            if (bus.timeout_err) bad++;
        end
        chk("to_no_err", bad, 0);
        chk("to_stuck_wait_start", dut.state_q == WAIT_START, 1);
        dead        = 1'b0;
        manual      = 1'b1;
        bus.tx_busy = 1'b1;
        repeat (3) @(negedge SYS_CLK);
        bus.tx_busy = 1'b0;
        @(negedge SYS_CLK);
        manual = 1'b0;
`endif
        wait_idle("to_drain_done");

        // Reset in WAIT_DONE; pointer left preferring source 1 beforehand
        @(negedge SYS_CLK);
        q0.push_back(8'h66);
        sb.push_back('{data: 8'h66, gid: 1'b0});
        upd_empty();
        wait_idle("pre_rst_done");
        @(negedge SYS_CLK);
        q0.push_back(8'h77);
        sb.push_back('{data: 8'h77, gid: 1'b0});
        upd_empty();
        n = 0;
        while (dut.state_q != WAIT_DONE && n < 30) begin
            @(negedge SYS_CLK);
            n++;
        end
        chk("rst_reach_wait_done", dut.state_q == WAIT_DONE, 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_r_req", bus.r_req, 2'b00);
        chk("arst_tx_start", bus.tx_start, 0);
        chk("arst_tx_data", bus.tx_data, 8'h00);
        chk("arst_grant_id", bus.grant_id, 0);
        chk("arst_timeout_err", bus.timeout_err, 0);
        chk("arst_state", dut.state_q == IDLE, 1);
        repeat (2) @(negedge SYS_CLK);
        RST_N = 1'b1;
        @(negedge SYS_CLK);
        q0.push_back(8'hE0);
        q1.push_back(8'hE1);
        sb.push_back('{data: 8'hE0, gid: 1'b0});
        sb.push_back('{data: 8'hE1, gid: 1'b1});
        upd_empty();
        wait_idle("post_rst_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side scheduler for the UART: it shares one UART transmitter between two byte FIFOs, source 0 (RX loopback/echo) and source 1 (host). It reads one byte from the granted FIFO and launches it on the transmitter. It waits for the frame to finish before the next grant. Sources are granted round-robin, so neither starves.

## Interface
Parameters:
- DATA_W, 8, byte width of FIFO read data and transmitter data
- TIMEOUT_CYC, 1024, cycles allowed for tx_busy to rise after tx_start (used only with timeout feature)

Ports:
- SYS_CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- empty  in  2  FIFO empty flags, bit n = source n
- r_req  out  2  FIFO read request, one-hot, one-cycle pulse
- r_data0  in  DATA_W  source 0 FIFO read data, valid the cycle after r_req[0]
- r_data1  in  DATA_W  source 1 FIFO read data, valid the cycle after r_req[1]
- tx_busy  in  1  transmitter busy, high for the duration of a frame
- tx_start  out  1  one-cycle launch pulse to transmitter
- tx_data  out  DATA_W  byte to transmit, held stable from tx_start until return to IDLE
- grant_id  out  1  source of the byte currently in flight
- timeout_err  out  1  one-cycle pulse: transmitter failed to start (timeout feature only, else tied 0)

## Operation
- All outputs are registered. Reset values: r_req=0, tx_start=0, tx_data=0, grant_id=0, timeout_err=0, state=IDLE, priority pointer=0 (source 0 preferred).
- FSM states: IDLE, READ, WAIT_DATA, WAIT_START, WAIT_DONE.
- IDLE: if tx_busy=0 and any empty[n]=0, grant one source:
  - both non-empty → grant the source the pointer prefers;
  - one non-empty → grant it.
  - Set r_req[n]=1 and grant_id=n, go to READ.
  - Never issue while tx_busy=1.
- READ: clear r_req, go to WAIT_DATA.
- WAIT_DATA: latch r_data of grant_id into tx_data, pulse tx_start=1, go to WAIT_START.
- WAIT_START: tx_start returns 0; wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: on tx_busy=0, flip pointer to prefer the non-granted source, go to IDLE.
- empty is sampled only in IDLE; changes in other states are ignored.
- Reset mid-operation: every register returns to its reset value; any in-flight byte is lost (already popped from FIFO). This is accepted behaviour.

## Timing
- Edge E0 (IDLE, request seen) → r_req high during E0–E1.
- E2 → tx_data valid and tx_start high during E2–E3. FIFO data is registered at E1 and sampled at E2.
- Latency from empty falling to tx_start: 2 cycles after the IDLE sampling edge.
- tx_busy falling to next r_req: 1 cycle (WAIT_DONE→IDLE at edge, IDLE issues at next edge). Minimum gap between tx_start pulses is frame length + 4 cycles.
- r_req never has both bits high. At most one read is outstanding.

## Configuration
- Macro UART_TX_SCHED_TIMEOUT_EN.
- Defined: WAIT_START uses a counter of width $clog2(TIMEOUT_CYC):
  - cleared on entry to WAIT_START;
  - if TIMEOUT_CYC cycles pass with tx_busy=0, pulse timeout_err for one cycle, drop the byte, leave the pointer unchanged, and go to IDLE.
  - A tx_busy rise on the final cycle wins over the timeout.
- Undefined: no counter; WAIT_START waits indefinitely; timeout_err tied 0.

## Structure
- Shared package uart_pkg holds:
  - the state enum uart_tx_sched_state_t;
  - UART_DATA_W=8;
  - source index constants SRC_ECHO=0 and SRC_HOST=1.
- One sub-module, uart_rr_arb2: a combinational two-requester round-robin pick from request bits and pointer, giving a one-hot grant. The pointer register stays in uart_tx_sched.

## Test plan
- Single byte: empty=2'b10, r_data0=8'hA5 → r_req=2'b01 one cycle, tx_start two cycles later, tx_data=8'hA5, grant_id=0.
- Contention: both FIFOs hold 3 bytes (src0 11,12,13; src1 21,22,23) → tx_data sequence 11,21,12,22,13,23.
- tx_busy held high in IDLE with data pending → no r_req until tx_busy=0, then r_req on the next edge.
- Timeout (macro defined, TIMEOUT_CYC=16): tx_busy never rises → timeout_err pulses exactly 16 cycles after tx_start, FSM in IDLE, the same source is regranted next if non-empty. Macro undefined → FSM stays in WAIT_START.
- Reset asserted in WAIT_DONE → all outputs 0 immediately (asynchronous), FSM in IDLE. After release, the next grant goes to source 0.
